// File: rtl/uart_echo_endpoint.sv
// uart_echo_endpoint
//   Echoes bytes received on an Avalon-ST sink back out of an Avalon-ST
//   source. Good bytes are optionally upcased and queued in a small FIFO.
//   Error beats are dropped and counted. Every 0x0D sent out is followed by
//   an inserted 0x0A.
//
// Parameters
//   DEPTH  : receive FIFO depth in bytes (power of two, >= 2)
//   UPCASE : 1 = map ASCII 'a'..'z' to 'A'..'Z' before queueing
//
// Ports
//   clk             : single clock, rising edge
//   reset           : asynchronous, active-high
//   from_uart_data  : sink byte
//   from_uart_error : sink framing/parity error for this beat
//   from_uart_valid : sink valid
//   from_uart_ready : sink ready (registered)
//   to_uart_data    : source byte (registered)
//   to_uart_error   : always 0
//   to_uart_valid   : source valid (registered)
//   to_uart_ready   : source ready
//   fifo_level      : bytes held in the FIFO, excluding the output register
//   err_count       : saturating count of discarded error beats
module uart_echo_endpoint #(
  parameter int DEPTH  = 8,
  parameter int UPCASE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               from_uart_data,
  input  logic                     from_uart_error,
  input  logic                     from_uart_valid,
  output logic                     from_uart_ready,
  output logic [7:0]               to_uart_data,
  output logic                     to_uart_error,
  output logic                     to_uart_valid,
  input  logic                     to_uart_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [7:0]               err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_DATA,
    S_LF
  } state_e;

  function automatic logic [7:0] upcase(input logic [7:0] b);
    if ((UPCASE != 0) && (b >= 8'h61) && (b <= 8'h7A)) begin
      return b - 8'h20;
    end
    return b;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          ready_q;
  logic [7:0]    err_q;
  state_e        state_q;
  logic [7:0]    data_q;
  logic          valid_q;

  logic          sink_acc;
  logic          push;
  logic          err_beat;
  logic          src_acc;
  logic          nonempty;
  logic          pop;
  logic [7:0]    head;

  assign sink_acc = from_uart_valid & ready_q;
  assign push     = sink_acc & ~from_uart_error;
  assign err_beat = sink_acc & from_uart_error;
  assign src_acc  = valid_q & to_uart_ready;
  assign nonempty = (level_q != '0);
  assign head     = mem_q[rd_ptr_q];

  // The head is only taken when the output register is free: from EMPTY,
  // or when the current byte leaves and no LF has to be inserted after it.
  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_EMPTY: pop = nonempty;
      S_DATA:  pop = src_acc && (data_q != CR) && nonempty;
      S_LF:    pop = src_acc && nonempty;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!push && pop) begin
      level_d = level_q - LW'(1);
    end
  end

  // FIFO storage holds data only; it needs no reset because the pointers
  // and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= upcase(from_uart_data);
    end
  end

  // Pointers, level, sink ready and error counter. Ready looks at the
  // post-edge level, so a full FIFO refuses a push even if it pops that cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      ready_q <= (level_d < LW'(DEPTH));
      if (err_beat) begin
        err_q <= sat_inc8(err_q);
      end
    end
  end

  // Output FSM with registered data/valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (pop) begin
            state_q <= S_DATA;
            data_q  <= head;
            valid_q <= 1'b1;
          end
        end
        S_DATA: begin
          if (src_acc) begin
            if (data_q == CR) begin
              state_q <= S_LF;
              data_q  <= LF;
              valid_q <= 1'b1;
            end else if (pop) begin
              state_q <= S_DATA;
              data_q  <= head;
              valid_q <= 1'b1;
            end else begin
              state_q <= S_EMPTY;
              valid_q <= 1'b0;
            end
          end
        end
        S_LF: begin
          if (src_acc) begin
            if (pop) begin
              state_q <= S_DATA;
              data_q  <= head;
              valid_q <= 1'b1;
            end else begin
              state_q <= S_EMPTY;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign from_uart_ready = ready_q;
  assign to_uart_data    = data_q;
  assign to_uart_valid   = valid_q;
  assign to_uart_error   = 1'b0;
  assign fifo_level      = level_q;
  assign err_count       = err_q;

endmodule

// File: tb/tb_uart_echo_endpoint.sv
module tb_uart_echo_endpoint;

  localparam int DEPTH = 8;

  logic       clk;
  logic       reset;
  logic [7:0] from_uart_data;
  logic       from_uart_error;
  logic       from_uart_valid;
  logic       from_uart_ready;
  logic [7:0] to_uart_data;
  logic       to_uart_error;
  logic       to_uart_valid;
  logic       to_uart_ready;
  logic [3:0] fifo_level;
  logic [7:0] err_count;

  uart_echo_endpoint #(.DEPTH(DEPTH), .UPCASE(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .from_uart_data  (from_uart_data),
    .from_uart_error (from_uart_error),
    .from_uart_valid (from_uart_valid),
    .from_uart_ready (from_uart_ready),
    .to_uart_data    (to_uart_data),
    .to_uart_error   (to_uart_error),
    .to_uart_valid   (to_uart_valid),
    .to_uart_ready   (to_uart_ready),
    .fifo_level      (fifo_level),
    .err_count       (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_upcase(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat and hold it until the DUT accepts it (bounded).
  // Returns just after the accepting edge with valid still high.
  task automatic send(input logic [7:0] d, input logic e);
    logic acc;
    bit   ok;
    ok = 0;
    from_uart_data  = d;
    from_uart_error = e;
    from_uart_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      acc = from_uart_ready;
      step();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: byte 0x%0h not accepted, expected acceptance", d);
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!to_uart_valid && fifo_level == 0 && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    exp_q.delete();
    step();
    step();
    reset = 1'b0;
    chk("ready_low_after_release", {31'd0, from_uart_ready}, 32'd0);
    step();
    chk("ready_first_edge", {31'd0, from_uart_ready}, 32'd1);
  endtask

  // Stream monitor: evaluated on the falling edge, it sees exactly the
  // values that the next rising edge will transfer.
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev  = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid_stable", {31'd0, to_uart_valid}, 32'd1);
        chk("stall_data_stable", {24'd0, to_uart_data}, {24'd0, data_prev});
      end
      if (from_uart_valid && from_uart_ready && !from_uart_error) begin
        exp_q.push_back(ref_upcase(from_uart_data));
        if (from_uart_data == 8'h0D) exp_q.push_back(8'h0A);
      end
      if (to_uart_valid && to_uart_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL extra_byte: got 0x%0h, expected no output", to_uart_data);
        end else begin
          chk("stream_order", {24'd0, to_uart_data}, {24'd0, exp_q.pop_front()});
        end
      end
      stall_prev = to_uart_valid && !to_uart_ready;
      data_prev  = to_uart_data;
    end
  end

  typedef struct {
    logic [7:0] din;
    logic       err;
    logic       exp_vld;
    logic [7:0] exp_dout;
    logic [7:0] exp_errcnt;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{8'h41, 1'b0, 1'b1, 8'h41, 8'd0};
    vecs[1]  = '{8'h61, 1'b0, 1'b1, 8'h41, 8'd0};
    vecs[2]  = '{8'h7A, 1'b0, 1'b1, 8'h5A, 8'd0};
    vecs[3]  = '{8'h60, 1'b0, 1'b1, 8'h60, 8'd0};
    vecs[4]  = '{8'h7B, 1'b0, 1'b1, 8'h7B, 8'd0};
    vecs[5]  = '{8'h20, 1'b1, 1'b0, 8'h00, 8'd1};
    vecs[6]  = '{8'h00, 1'b0, 1'b1, 8'h00, 8'd1};
    vecs[7]  = '{8'h6D, 1'b1, 1'b0, 8'h00, 8'd2};
    vecs[8]  = '{8'hFF, 1'b0, 1'b1, 8'hFF, 8'd2};
    vecs[9]  = '{8'h0A, 1'b0, 1'b1, 8'h0A, 8'd2};
    vecs[10] = '{8'h40, 1'b0, 1'b1, 8'h40, 8'd2};
  end

  bit         done;
  bit         quiet;
  logic [7:0] rb;

  initial begin
    reset           = 1'b0;
    from_uart_data  = 8'h00;
    from_uart_error = 1'b0;
    from_uart_valid = 1'b0;
    to_uart_ready   = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_ready", {31'd0, from_uart_ready}, 32'd0);
    chk("rst_valid", {31'd0, to_uart_valid}, 32'd0);
    chk("rst_data", {24'd0, to_uart_data}, 32'd0);
    chk("rst_level", {28'd0, fifo_level}, 32'd0);
    chk("rst_errcnt", {24'd0, err_count}, 32'd0);
    chk("tx_error_tied", {31'd0, to_uart_error}, 32'd0);
    step();
    step();
    reset = 1'b0;
    chk("ready_low_after_release", {31'd0, from_uart_ready}, 32'd0);
    step();
    chk("ready_first_edge", {31'd0, from_uart_ready}, 32'd1);

    // Single-beat vectors with an always-ready sink downstream.
    to_uart_ready = 1'b1;
    foreach (vecs[i]) begin
      chk($sformatf("vec%0d_ready", i), {31'd0, from_uart_ready}, 32'd1);
      send(vecs[i].din, vecs[i].err);
      from_uart_valid = 1'b0;
      chk($sformatf("vec%0d_level", i), {28'd0, fifo_level}, {31'd0, vecs[i].exp_vld});
      chk($sformatf("vec%0d_errcnt", i), {24'd0, err_count}, {24'd0, vecs[i].exp_errcnt});
      chk($sformatf("vec%0d_valid_early", i), {31'd0, to_uart_valid}, 32'd0);
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, to_uart_valid}, {31'd0, vecs[i].exp_vld});
      if (vecs[i].exp_vld)
        chk($sformatf("vec%0d_data", i), {24'd0, to_uart_data}, {24'd0, vecs[i].exp_dout});
      step();
      chk($sformatf("vec%0d_empty", i), {31'd0, to_uart_valid}, 32'd0);
    end

    // "hi\r" back to back -> H I CR LF with no bubble.
    send(8'h68, 1'b0);
    send(8'h69, 1'b0);
    chk("hi_out0", {23'd0, to_uart_valid, to_uart_data}, {23'd0, 1'b1, 8'h48});
    send(8'h0D, 1'b0);
    from_uart_valid = 1'b0;
    chk("hi_out1", {23'd0, to_uart_valid, to_uart_data}, {23'd0, 1'b1, 8'h49});
    step();
    chk("hi_out2", {23'd0, to_uart_valid, to_uart_data}, {23'd0, 1'b1, 8'h0D});
    step();
    chk("hi_out3", {23'd0, to_uart_valid, to_uart_data}, {23'd0, 1'b1, 8'h0A});
    step();
    chk("hi_idle", {31'd0, to_uart_valid}, 32'd0);

    // Fill: nine bytes with the downstream stalled.
    to_uart_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h30 + 8'(i), 1'b0);
    from_uart_valid = 1'b0;
    chk("full_level", {28'd0, fifo_level}, 32'd8);
    chk("full_ready", {31'd0, from_uart_ready}, 32'd0);
    chk("full_out", {23'd0, to_uart_valid, to_uart_data}, {23'd0, 1'b1, 8'h30});
    from_uart_data  = 8'h39;
    from_uart_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_refuses", {28'd0, fifo_level}, 32'd8);
    end
    from_uart_valid = 1'b0;
    to_uart_ready   = 1'b1;
    wait_drain("full_drain");

    // Error beats: 3 then 300 more, counter saturates.
    do_reset();
    quiet = 1;
    for (int i = 0; i < 3; i++) send(8'h55, 1'b1);
    from_uart_valid = 1'b0;
    chk("err3_count", {24'd0, err_count}, 32'd3);
    for (int i = 0; i < 300; i++) begin
      send(8'h55, 1'b1);
      if (to_uart_valid) quiet = 0;
    end
    from_uart_valid = 1'b0;
    step();
    chk("err_no_output", {31'd0, quiet}, 32'd1);
    chk("err_saturated", {24'd0, err_count}, 32'd255);

    // 100 bytes with random gaps and random downstream back-pressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          rb = (i % 10 == 3) ? 8'h0D : 8'($urandom_range(0, 255));
          send(rb, 1'b0);
          if ($urandom_range(0, 3) == 0) begin
            from_uart_valid = 1'b0;
            step();
          end
        end
        from_uart_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          to_uart_ready = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    to_uart_ready = 1'b1;
    wait_drain("random_drain");

    // Reset in the middle of a cycle with bytes queued.
    to_uart_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i), 1'b0);
    from_uart_valid = 1'b0;
    chk("pre_rst_level", {28'd0, fifo_level}, 32'd4);
    @(posedge clk);
    #3 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_ready", {31'd0, from_uart_ready}, 32'd0);
    chk("mid_rst_valid", {31'd0, to_uart_valid}, 32'd0);
    chk("mid_rst_data", {24'd0, to_uart_data}, 32'd0);
    chk("mid_rst_level", {28'd0, fifo_level}, 32'd0);
    chk("mid_rst_errcnt", {24'd0, err_count}, 32'd0);
    step();
    reset = 1'b0;
    to_uart_ready = 1'b1;
    quiet = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (to_uart_valid || fifo_level != 0) quiet = 0;
    end
    chk("no_stale_after_reset", {31'd0, quiet}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
